// File: rtl/ex_brn_resolve_if.sv
// ============================================================================
// Interface : ex_brn_resolve_if
// Purpose   : Groups the issue-execute control-flow fields consumed by the
//             branch resolver and the redirect / flush / predictor-update
//             results it returns.
// Modports  : master - pipeline side (drives EX fields, receives results)
//             slave  - ex_brn_resolve (receives EX fields, drives results)
// Signals   : valid_i, op_i[6:0], funct3_i[2:0], is_b_type_i, jump_i,
//             brn_pred_i, r_data_p1_i, r_data_p2_i, sext_imm_12bit_i,
//             curr_pc_i, next_seq_pc_i, next_brn_pc_i, next_pred_pc_i,
//             redirect_o, redirect_pc_o, flush_o, bp_upd_valid_o,
//             bp_upd_pc_o, bp_upd_taken_o, bp_upd_target_o,
//             brn_cnt_o / mispred_cnt_o (only with BRN_STATS_EN defined)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_brn_resolve_if #(
   parameter int CNT_W = 32
);
   // EX-stage fields
   logic        valid_i;
   logic [6:0]  op_i;
   logic [2:0]  funct3_i;
   logic        is_b_type_i;
   logic        jump_i;
   logic        brn_pred_i;
   logic [31:0] r_data_p1_i;
   logic [31:0] r_data_p2_i;
   logic [31:0] sext_imm_12bit_i;
   logic [31:0] curr_pc_i;
   logic [31:0] next_seq_pc_i;
   logic [31:0] next_brn_pc_i;
   logic [31:0] next_pred_pc_i;

   // Resolution results
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        flush_o;
   logic        bp_upd_valid_o;
   logic [31:0] bp_upd_pc_o;
   logic        bp_upd_taken_o;
   logic [31:0] bp_upd_target_o;
`ifdef BRN_STATS_EN
   logic [CNT_W-1:0] brn_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;
`endif

   modport master (
      output valid_i, op_i, funct3_i, is_b_type_i, jump_i, brn_pred_i,
             r_data_p1_i, r_data_p2_i, sext_imm_12bit_i, curr_pc_i,
             next_seq_pc_i, next_brn_pc_i, next_pred_pc_i,
      input  redirect_o, redirect_pc_o, flush_o, bp_upd_valid_o,
             bp_upd_pc_o, bp_upd_taken_o, bp_upd_target_o
`ifdef BRN_STATS_EN
      , input brn_cnt_o, mispred_cnt_o
`endif
   );

   modport slave (
      input  valid_i, op_i, funct3_i, is_b_type_i, jump_i, brn_pred_i,
             r_data_p1_i, r_data_p2_i, sext_imm_12bit_i, curr_pc_i,
             next_seq_pc_i, next_brn_pc_i, next_pred_pc_i,
      output redirect_o, redirect_pc_o, flush_o, bp_upd_valid_o,
             bp_upd_pc_o, bp_upd_taken_o, bp_upd_target_o
`ifdef BRN_STATS_EN
      , output brn_cnt_o, mispred_cnt_o
`endif
   );
endinterface

`default_nettype wire

// File: rtl/ex_brn_resolve.sv
// ============================================================================
// Module    : ex_brn_resolve
// Purpose   : Execute-stage branch/jump resolver. Computes the real next PC,
//             compares it with the PC fetch followed, and on a mispredict
//             redirects fetch, holds the upstream pipe registers in flush for
//             FLUSH_CYC cycles and squashes wrong-path instructions meanwhile.
//             Every resolved branch/jump produces a predictor update packet.
// Ports     : clk   - clock
//             reset - synchronous, active-high reset
//             bus   - ex_brn_resolve_if.slave (EX fields in, results out)
// Params    : FLUSH_CYC - flush window length in cycles (>=1)
//             CNT_W     - statistics counter width
// Options   : BRN_STATS_EN - builds the branch / mispredict counters
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_brn_resolve #(
   parameter int FLUSH_CYC = 2,
   parameter int CNT_W     = 32
) (
   input  wire logic        clk,
   input  wire logic        reset,
   ex_brn_resolve_if.slave  bus
);

   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam int              FC_W       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYC - 1);

   // ------------------------------------------------------------------------
   // Resolution (combinational)
   // ------------------------------------------------------------------------
   logic        cond_true;
   logic        cond_known;
   logic        is_jalr;
   logic        taken_dir;
   logic [31:0] jalr_target;
   logic [31:0] actual_pc;
   logic        resolve;
   logic        mispredict;
   logic        upd_fire;

   logic [0:0]      state;
   logic [FC_W-1:0] flush_cnt;

   always_comb begin
      cond_true  = 1'b0;
      cond_known = 1'b1;
      case (bus.funct3_i)
         3'b000:  cond_true = (bus.r_data_p1_i == bus.r_data_p2_i);
         3'b001:  cond_true = (bus.r_data_p1_i != bus.r_data_p2_i);
         3'b100:  cond_true = ($signed(bus.r_data_p1_i) <  $signed(bus.r_data_p2_i));
         3'b101:  cond_true = ($signed(bus.r_data_p1_i) >= $signed(bus.r_data_p2_i));
         3'b110:  cond_true = (bus.r_data_p1_i <  bus.r_data_p2_i);
         3'b111:  cond_true = (bus.r_data_p1_i >= bus.r_data_p2_i);
         // 010/011 are not branch conditions: treated as not-taken and never
         // reported to the predictor.
         default: cond_known = 1'b0;
      endcase
   end

   assign is_jalr     = (bus.op_i == OP_JALR);
   assign jalr_target = (bus.r_data_p1_i + bus.sext_imm_12bit_i) & ~32'h1;
   assign taken_dir   = bus.jump_i | (bus.is_b_type_i & cond_true);
   assign actual_pc   = is_jalr   ? jalr_target :
                        taken_dir ? bus.next_brn_pc_i : bus.next_seq_pc_i;

   // Anything arriving while a flush is in progress is wrong-path.
   assign resolve    = bus.valid_i && (state == ST_IDLE);
   assign mispredict = resolve && (bus.is_b_type_i || bus.jump_i) &&
                       (actual_pc != bus.next_pred_pc_i);
   assign upd_fire   = resolve && (bus.jump_i || (bus.is_b_type_i && cond_known));

   // ------------------------------------------------------------------------
   // Registered outputs and flush FSM
   // ------------------------------------------------------------------------
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         flush_cnt   <= '0;
         flush       <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         upd_valid   <= 1'b0;
         upd_pc      <= '0;
         upd_taken   <= 1'b0;
         upd_target  <= '0;
      end else begin
         redirect  <= mispredict;
         upd_valid <= upd_fire;

         if (mispredict) begin
            redirect_pc <= actual_pc;
         end

         if (upd_fire) begin
            upd_pc     <= bus.curr_pc_i;
            upd_taken  <= taken_dir;
            upd_target <= actual_pc;
         end

         case (state)
            ST_IDLE: begin
               if (mispredict) begin
                  state     <= ST_FLUSH;
                  flush     <= 1'b1;
                  flush_cnt <= FLUSH_LOAD;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= ST_IDLE;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               flush <= 1'b0;
            end
         endcase
      end
   end

   assign bus.redirect_o      = redirect;
   assign bus.redirect_pc_o   = redirect_pc;
   assign bus.flush_o         = flush;
   assign bus.bp_upd_valid_o  = upd_valid;
   assign bus.bp_upd_pc_o     = upd_pc;
   assign bus.bp_upd_taken_o  = upd_taken;
   assign bus.bp_upd_target_o = upd_target;

`ifdef BRN_STATS_EN
   // ------------------------------------------------------------------------
   // Statistics: count the registered strobes so each event counts once.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] brn_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         brn_cnt     <= '0;
         mispred_cnt <= '0;
      end else begin
         if (upd_valid) begin
            brn_cnt <= brn_cnt + 1'b1;
         end
         if (redirect) begin
            mispred_cnt <= mispred_cnt + 1'b1;
         end
      end
   end

   assign bus.brn_cnt_o     = brn_cnt;
   assign bus.mispred_cnt_o = mispred_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_brn_resolve.sv
// ============================================================================
// Testbench : tb_ex_brn_resolve
// Purpose   : Directed scenarios plus randomized traffic for ex_brn_resolve,
//             checked against a cycle-level reference model.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_brn_resolve;

   localparam int         FLUSH_CYC = 2;
   localparam int         CNT_W     = 32;
   localparam logic [6:0] OP_BR     = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ALU    = 7'b0010011;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   ex_brn_resolve_if #(.CNT_W(CNT_W)) bus ();

   ex_brn_resolve #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference rules ----------------
   function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return !($signed(a) < $signed(b));
         3'd6:    return a < b;
         3'd7:    return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_next_pc(input logic [6:0] op, input logic jmp, input logic isb,
                                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] imm, input logic [31:0] seq, input logic [31:0] brn);
      if (op == OP_JALR) return (a + imm) & 32'hFFFF_FFFE;
      if (jmp || (isb && ref_cond(f3, a, b))) return brn;
      return seq;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive_idle();
      bus.valid_i = 1'b0; bus.op_i = OP_ALU; bus.funct3_i = 3'd0; bus.is_b_type_i = 1'b0;
      bus.jump_i = 1'b0; bus.brn_pred_i = 1'b0; bus.r_data_p1_i = '0; bus.r_data_p2_i = '0;
      bus.sext_imm_12bit_i = '0; bus.curr_pc_i = '0; bus.next_seq_pc_i = '0;
      bus.next_brn_pc_i = '0; bus.next_pred_pc_i = '0;
   endtask

   task automatic drive_instr(input logic [6:0] op, input logic [2:0] f3, input logic isb, input logic jmp,
                              input logic pred, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] brn,
                              input logic [31:0] pred_pc);
      bus.valid_i = 1'b1; bus.op_i = op; bus.funct3_i = f3; bus.is_b_type_i = isb; bus.jump_i = jmp;
      bus.brn_pred_i = pred; bus.r_data_p1_i = a; bus.r_data_p2_i = b; bus.sext_imm_12bit_i = imm;
      bus.curr_pc_i = pc; bus.next_seq_pc_i = pc + 32'd4; bus.next_brn_pc_i = brn;
      bus.next_pred_pc_i = pred_pc;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      drive_instr(OP_BR, 3'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h80, 32'h44);
      step(); step();
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 4'b0000 ||
          bus.redirect_pc_o !== 32'h0 || bus.bp_upd_pc_o !== 32'h0 || bus.bp_upd_target_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: ctl=%b rpc=%h upc=%h tgt=%h expected all zero",
                  {bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o},
                  bus.redirect_pc_o, bus.bp_upd_pc_o, bus.bp_upd_target_o);
      end
`ifdef BRN_STATS_EN
      checks++;
      if (bus.brn_cnt_o !== '0 || bus.mispred_cnt_o !== '0) begin
         failures++;
         $display("FAIL reset_counters: brn=%0d mis=%0d expected 0 0", bus.brn_cnt_o, bus.mispred_cnt_o);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      drive_idle();
   endtask

   task automatic test_beq_correct();
      @(negedge clk);
      drive_instr(OP_BR, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 32'h40, 32'h100, 32'h100);
      step();
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 4'b0011 ||
          bus.bp_upd_target_o !== 32'h100 || bus.bp_upd_pc_o !== 32'h40) begin
         failures++;
         $display("FAIL beq_taken: ctl=%b tgt=%h pc=%h expected ctl=0011 tgt=00000100 pc=00000040",
                  {bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o},
                  bus.bp_upd_target_o, bus.bp_upd_pc_o);
      end
      @(negedge clk); drive_idle(); step();
      checks++;
      if (bus.bp_upd_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL upd_pulse_width: got %b expected 0", bus.bp_upd_valid_o);
      end
   endtask

   task automatic test_blt_mispredict();
      @(negedge clk);
      drive_instr(OP_BR, 3'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h80, 32'h44);
      step();
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 4'b1111 ||
          bus.redirect_pc_o !== 32'h80 || bus.bp_upd_target_o !== 32'h80) begin
         failures++;
         $display("FAIL blt_redirect: ctl=%b rpc=%h tgt=%h expected ctl=1111 rpc=00000080 tgt=00000080",
                  {bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o},
                  bus.redirect_pc_o, bus.bp_upd_target_o);
      end
      @(negedge clk); drive_idle(); step();
      checks++;
      if (bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b1 || bus.redirect_pc_o !== 32'h80) begin
         failures++;
         $display("FAIL blt_flush2: redirect=%b flush=%b rpc=%h expected 0 1 00000080",
                  bus.redirect_o, bus.flush_o, bus.redirect_pc_o);
      end
      step();
      checks++;
      if (bus.flush_o !== 1'b0) begin
         failures++;
         $display("FAIL blt_flush_end: flush=%b expected 0", bus.flush_o);
      end
   endtask

   task automatic test_bltu_correct();
      @(negedge clk);
      drive_instr(OP_BR, 3'd6, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h80, 32'h44);
      step();
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 4'b0010 ||
          bus.bp_upd_target_o !== 32'h44) begin
         failures++;
         $display("FAIL bltu_not_taken: ctl=%b tgt=%h expected ctl=0010 tgt=00000044",
                  {bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o}, bus.bp_upd_target_o);
      end
      @(negedge clk); drive_idle();
   endtask

   task automatic test_jalr();
      @(negedge clk);
      drive_instr(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b1, 32'h1003, 32'd0, 32'h10, 32'h500, 32'h600, 32'h2000);
      step();
      checks++;
      if ({bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 4'b1111 ||
          bus.redirect_pc_o !== 32'h1012 || bus.bp_upd_pc_o !== 32'h500) begin
         failures++;
         $display("FAIL jalr_redirect: ctl=%b rpc=%h upc=%h expected ctl=1111 rpc=00001012 upc=00000500",
                  {bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o},
                  bus.redirect_pc_o, bus.bp_upd_pc_o);
      end
      @(negedge clk); drive_idle(); step(); step();
   endtask

   task automatic test_squash();
      @(negedge clk);
      drive_instr(OP_BR, 3'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h80, 32'h44);
      step();
      for (int k = 0; k < FLUSH_CYC; k++) begin
         @(negedge clk);
         drive_instr(OP_BR, 3'd1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd9, 32'd0, 32'h90, 32'h300, 32'h999);
         step();
         checks++;
         if (bus.redirect_o !== 1'b0 || bus.bp_upd_valid_o !== 1'b0 || bus.redirect_pc_o !== 32'h80) begin
            failures++;
            $display("FAIL squash_%0d: redirect=%b upd=%b rpc=%h expected 0 0 00000080",
                     k, bus.redirect_o, bus.bp_upd_valid_o, bus.redirect_pc_o);
         end
      end
      @(negedge clk); drive_idle(); step();
   endtask

   task automatic test_reset_mid_flush();
      @(negedge clk);
      drive_instr(OP_BR, 3'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h80, 32'h44);
      step();
      @(negedge clk);
      drive_idle();
      reset = 1'b1;
      step();
      checks++;
      if (bus.flush_o !== 1'b0 || bus.redirect_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_flush: flush=%b redirect=%b expected 0 0", bus.flush_o, bus.redirect_o);
      end
      @(negedge clk);
      reset = 1'b0;
      drive_instr(OP_BR, 3'd0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0, 32'h20, 32'h200, 32'h200);
      step();
      checks++;
      if (bus.bp_upd_valid_o !== 1'b1 || bus.flush_o !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: upd=%b flush=%b expected 1 0", bus.bp_upd_valid_o, bus.flush_o);
      end
      @(negedge clk); drive_idle(); step();
   endtask

`ifdef BRN_STATS_EN
   task automatic test_stats();
      @(negedge clk); reset = 1'b1; step();
      @(negedge clk); reset = 1'b0;
      drive_instr(OP_BR, 3'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h80, 32'h44);
      step();
      @(negedge clk); drive_idle(); step(); step();
      @(negedge clk);
      drive_instr(OP_BR, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 32'h40, 32'h100, 32'h100);
      step();
      @(negedge clk);
      drive_instr(OP_BR, 3'd6, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h80, 32'h44);
      step();
      @(negedge clk); drive_idle(); step(); step();
      checks++;
      if (bus.brn_cnt_o !== 32'd3 || bus.mispred_cnt_o !== 32'd1) begin
         failures++;
         $display("FAIL stats_counts: brn=%0d mis=%0d expected 3 1", bus.brn_cnt_o, bus.mispred_cnt_o);
      end
   endtask
`endif

   task automatic test_random();
      logic        e_redirect = 1'b0, e_flush = 1'b0, e_upd = 1'b0, e_taken = 1'b0;
      logic [31:0] e_rpc = '0, e_upc = '0, e_tgt = '0, npc;
      int          flush_left = 0;
      logic [31:0] e_brn_cnt = '0, e_mis_cnt = '0;
      logic        live, mis, upd;
      int          kind;

      @(negedge clk); reset = 1'b1; drive_idle(); step();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 59) == 0);
         kind  = $urandom_range(0, 3);
         bus.valid_i          = ($urandom_range(0, 4) != 0);
         bus.funct3_i         = 3'($urandom_range(0, 7));
         bus.brn_pred_i       = 1'($urandom_range(0, 1));
         bus.r_data_p1_i      = $urandom;
         bus.r_data_p2_i      = ($urandom_range(0, 2) == 0) ? bus.r_data_p1_i : $urandom;
         bus.sext_imm_12bit_i = 32'($signed(12'($urandom)));
         bus.curr_pc_i        = $urandom & 32'hFFFF_FFFC;
         bus.next_seq_pc_i    = bus.curr_pc_i + 32'd4;
         bus.next_brn_pc_i    = bus.curr_pc_i + 32'($signed(13'($urandom)) & -32'sd2);
         bus.op_i             = (kind == 0) ? OP_BR : (kind == 1) ? OP_JAL : (kind == 2) ? OP_JALR : OP_ALU;
         bus.is_b_type_i      = (kind == 0);
         bus.jump_i           = (kind == 1) || (kind == 2);
         npc = ref_next_pc(bus.op_i, bus.jump_i, bus.is_b_type_i, bus.funct3_i, bus.r_data_p1_i,
                           bus.r_data_p2_i, bus.sext_imm_12bit_i, bus.next_seq_pc_i, bus.next_brn_pc_i);
         case ($urandom_range(0, 4))
            0:       bus.next_pred_pc_i = bus.next_seq_pc_i;
            1:       bus.next_pred_pc_i = bus.next_brn_pc_i;
            2:       bus.next_pred_pc_i = $urandom;
            default: bus.next_pred_pc_i = npc;
         endcase

         if (reset) begin
            {e_redirect, e_flush, e_upd, e_taken} = 4'b0000;
            e_rpc = '0; e_upc = '0; e_tgt = '0; flush_left = 0;
            e_brn_cnt = '0; e_mis_cnt = '0;
         end else begin
            e_brn_cnt = e_brn_cnt + 32'(e_upd);
            e_mis_cnt = e_mis_cnt + 32'(e_redirect);
            live = bus.valid_i && (flush_left == 0);
            mis  = live && (bus.is_b_type_i || bus.jump_i) && (npc != bus.next_pred_pc_i);
            upd  = live && (bus.jump_i || (bus.is_b_type_i && bus.funct3_i[2:1] != 2'b01));
            e_redirect = mis;
            if (mis) e_rpc = npc;
            e_upd = upd;
            if (upd) begin
               e_upc   = bus.curr_pc_i;
               e_taken = bus.jump_i || ref_cond(bus.funct3_i, bus.r_data_p1_i, bus.r_data_p2_i);
               e_tgt   = npc;
            end
            if (mis) flush_left = FLUSH_CYC;
            else if (flush_left > 0) flush_left--;
            e_flush = (flush_left > 0);
         end

         step();
         checks++;
         if ({bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o} !==
             {e_redirect, e_flush, e_upd, e_taken}) begin
            failures++;
            $display("FAIL rand_ctl[%0d]: got %b expected %b", n,
                     {bus.redirect_o, bus.flush_o, bus.bp_upd_valid_o, bus.bp_upd_taken_o},
                     {e_redirect, e_flush, e_upd, e_taken});
         end
         checks++;
         if (bus.redirect_pc_o !== e_rpc || bus.bp_upd_pc_o !== e_upc || bus.bp_upd_target_o !== e_tgt) begin
            failures++;
            $display("FAIL rand_pcs[%0d]: got rpc=%h upc=%h tgt=%h expected %h %h %h", n,
                     bus.redirect_pc_o, bus.bp_upd_pc_o, bus.bp_upd_target_o, e_rpc, e_upc, e_tgt);
         end
`ifdef BRN_STATS_EN
         checks++;
         if (bus.brn_cnt_o !== e_brn_cnt || bus.mispred_cnt_o !== e_mis_cnt) begin
            failures++;
            $display("FAIL rand_stats[%0d]: got %0d %0d expected %0d %0d", n,
                     bus.brn_cnt_o, bus.mispred_cnt_o, e_brn_cnt, e_mis_cnt);
         end
`endif
      end
      @(negedge clk); reset = 1'b0; drive_idle(); step(); step(); step();
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      test_reset();
      test_beq_correct();
      test_blt_mispredict();
      test_bltu_correct();
      test_jalr();
      test_squash();
      test_reset_mid_flush();
`ifdef BRN_STATS_EN
      test_stats();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
